// File: rtl/barrel_shift_pkg.sv
// Shared types and the per-level shift helper for the pipelined right shifter.
// Rotate support is compiled in only when BARREL_ROTATE_EN is defined.
package barrel_shift_pkg;

   localparam int BS_WIDTH  = 16;
   localparam int BS_CTRL_W = 4;

   typedef struct packed {
      logic [BS_WIDTH-1:0]  data;
      logic [BS_CTRL_W-1:0] shamt;
      logic                 fill;
      logic                 rot;
   } bs_beat_t;

   function automatic logic [BS_WIDTH-1:0] bs_stage_shift(
      input logic [BS_WIDTH-1:0] data,
      input logic                fill,
      input logic                rot,
      input int                  amt,
      input logic                en
   );
      logic [2*BS_WIDTH-1:0] ext;
      logic [BS_WIDTH-1:0]   hi;
      // Upper half supplies the vacated bits: a copy of data rotates, fill shifts.
      hi  = rot ? data : {BS_WIDTH{fill}};
      ext = {hi, data} >> amt;
      return en ? ext[BS_WIDTH-1:0] : data;
   endfunction

endpackage

// File: rtl/barrel_shift_16bit_right_pipe_rshift_stage.sv
// One mux level of the right shifter and the pipeline register behind it.
// Optional rotate path is selected by BARREL_ROTATE_EN.
module rshift_stage
   import barrel_shift_pkg::*;
#(
   parameter int SHIFT = 1
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     up_valid,
   output logic     up_ready,
   input  bs_beat_t up_beat,
   output logic     dn_valid,
   input  logic     dn_ready,
   output bs_beat_t dn_beat
);

   localparam int BIT = $clog2(SHIFT);

   logic     v_q;
   logic     v_d;
   bs_beat_t beat_q;
   bs_beat_t beat_d;
   logic     load;
   logic     rot_eff;

`ifdef BARREL_ROTATE_EN
   assign rot_eff = up_beat.rot;
`else
   assign rot_eff = 1'b0;
`endif

   always_comb begin
      load   = !v_q || dn_ready;
      v_d    = load ? up_valid : v_q;
      beat_d = beat_q;
      if (load && up_valid) begin
         beat_d      = up_beat;
         beat_d.data = bs_stage_shift(up_beat.data,
                                      up_beat.fill,
                                      rot_eff,
                                      SHIFT,
                                      up_beat.shamt[BIT]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q    <= 1'b0;
         beat_q <= '0;
      end else begin
         v_q    <= v_d;
         beat_q <= beat_d;
      end
   end

   assign up_ready = load;
   assign dn_valid = v_q;
   assign dn_beat  = beat_q;

endmodule

// File: rtl/barrel_shift_16bit_right_pipe.sv
// Pipelined 16-bit right barrel shifter (8,4,2,1 levels) with valid/ready.
// Define BARREL_ROTATE_EN to add the in_rot port and rotate-right mode.
module barrel_shift_16bit_right_pipe
   import barrel_shift_pkg::*;
#(
   parameter int  WIDTH  = BS_WIDTH,
   localparam int CTRL_W = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   input  logic [CTRL_W-1:0] in_shamt,
   input  logic              in_arith,
`ifdef BARREL_ROTATE_EN
   input  logic              in_rot,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data
);

   bs_beat_t              in_beat;
   bs_beat_t [CTRL_W:0]   beat;
   logic     [CTRL_W:0]   vld;
   logic     [CTRL_W:0]   rdy;
   logic                  unused_tail;

   // Fill bit is fixed at the input so later levels never see the original MSB.
   always_comb begin
      in_beat       = '0;
      in_beat.data  = in_data;
      in_beat.shamt = in_shamt;
      in_beat.fill  = in_arith & in_data[WIDTH-1];
`ifdef BARREL_ROTATE_EN
      in_beat.rot   = in_rot;
`endif
   end

   assign beat[0]     = in_beat;
   assign vld[0]      = in_valid;
   assign in_ready    = rdy[0];
   assign rdy[CTRL_W] = out_ready;

   for (genvar k = 0; k < CTRL_W; k++) begin : g_stage
      rshift_stage #(
         .SHIFT (1 << (CTRL_W - 1 - k))
      ) u_stage (
         .clk      (clk),
         .rst      (rst),
         .up_valid (vld[k]),
         .up_ready (rdy[k]),
         .up_beat  (beat[k]),
         .dn_valid (vld[k+1]),
         .dn_ready (rdy[k+1]),
         .dn_beat  (beat[k+1])
      );
   end

   assign out_valid   = vld[CTRL_W];
   assign out_data    = beat[CTRL_W].data;
   assign unused_tail = ^{beat[CTRL_W].shamt,
                          beat[CTRL_W].fill,
                          beat[CTRL_W].rot};

endmodule

// File: tb/tb_barrel_shift_16bit_right_pipe.sv
// Bench for barrel_shift_16bit_right_pipe: directed table, corner sequences,
// random traffic vs a queue scoreboard. Rotate cases need BARREL_ROTATE_EN.
`timescale 1ns/1ps
module tb_barrel_shift_16bit_right_pipe;

`ifdef BARREL_ROTATE_EN
   localparam bit ROT_EN = 1'b1;
`else
   localparam bit ROT_EN = 1'b0;
`endif

   typedef struct {
      string       name;
      logic [15:0] data;
      logic [3:0]  shamt;
      logic        arith;
      logic        rot;
      logic [15:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic [3:0]  in_shamt = '0;
   logic        in_arith = 1'b0;
   logic        in_rot = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;

   int n_pass = 0;
   int n_chk  = 0;
   int n_acc  = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   barrel_shift_16bit_right_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_arith  (in_arith),
`ifdef BARREL_ROTATE_EN
      .in_rot    (in_rot),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   function automatic logic [15:0] ref_shift(input logic [15:0] x,
                                             input int n,
                                             input logic arith,
                                             input logic rot);
      if (rot && ROT_EN)
         return (n == 0) ? x : 16'((x >> n) | (x << (16 - n)));
      if (arith)
         return 16'($signed(x) >>> n);
      return x >> n;
   endfunction

   task automatic check(input string name, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, got, exp);
   endtask

   // Scoreboard: every accepted beat must emerge once, in order, with the model value.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_shift(in_data, int'(in_shamt),
                                      in_arith, in_rot));
            n_acc++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0)
               check("stray_beat", 32'(out_valid), 0);
            else
               check("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic send_one(input vec_t v, output int lat,
                           output logic [15:0] got);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = v.data;
      in_shamt = v.shamt;
      in_arith = v.arith;
      in_rot   = v.rot && ROT_EN;
      do begin
         @(negedge clk);
         guard++;
      end while (!in_ready && guard < 20);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      got = out_data;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t        tbl[$];
      int          lat;
      int          idx;
      int          cnt;
      int          cyc;
      int          start;
      logic [15:0] got;

      tbl.push_back('{"lsr1",     16'h8001, 4'd1,  1'b0, 1'b0, 16'h4000});
      tbl.push_back('{"asr4",     16'h8001, 4'd4,  1'b1, 1'b0, 16'hF800});
      tbl.push_back('{"lsr4",     16'h8001, 4'd4,  1'b0, 1'b0, 16'h0800});
      tbl.push_back('{"sh0",      16'hF0F0, 4'd0,  1'b1, 1'b0, 16'hF0F0});
      tbl.push_back('{"lsr15",    16'hF0F0, 4'd15, 1'b0, 1'b0, 16'h0001});
      tbl.push_back('{"asr15",    16'h8000, 4'd15, 1'b1, 1'b0, 16'hFFFF});
      tbl.push_back('{"asr15pos", 16'h7FFF, 4'd15, 1'b1, 1'b0, 16'h0000});
      tbl.push_back('{"lsr8",     16'h1234, 4'd8,  1'b0, 1'b0, 16'h0012});
`ifdef BARREL_ROTATE_EN
      tbl.push_back('{"rot4",     16'h1234, 4'd4,  1'b0, 1'b1, 16'h4123});
      tbl.push_back('{"rotarith", 16'h8001, 4'd1,  1'b1, 1'b1, 16'hC000});
      tbl.push_back('{"rot0",     16'h1234, 4'd0,  1'b0, 1'b1, 16'h1234});
`endif

      // Reset state
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data", 32'(out_data), 0);
      rst = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 1);
      @(posedge clk); #1;

      // Directed table: value and latency
      foreach (tbl[i]) begin
         send_one(tbl[i], lat, got);
         check(tbl[i].name, 32'(got), 32'(tbl[i].exp));
         check("latency", lat, 4);
      end
      @(posedge clk); #1;

      // Backpressure: only four beats fit, head held stable
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 8; c++) begin
         in_valid = 1'b1;
         in_data  = 16'hA000 + 16'(idx);
         in_shamt = 4'd0;
         in_arith = 1'b0;
         in_rot   = 1'b0;
         @(negedge clk);
         if (in_ready) idx++;
         @(posedge clk); #1;
      end
      check("bp_accepted", idx, 4);
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_head", 32'(out_data), 32'h0000_A000);
      repeat (3) @(posedge clk);
      #1;
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_hold_data", 32'(out_data), 32'h0000_A000);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      check("bp_ready_release", 32'(in_ready), 1);
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check("bp_stream_valid", 32'(out_valid), 1);
      end
      @(negedge clk);
      check("bp_empty_after", 32'(out_valid), 0);
      check("bp_drained", exp_q.size(), 0);
      @(posedge clk); #1;

      // Reset while three beats are in flight
      for (int j = 0; j < 3; j++) begin
         in_valid = 1'b1;
         in_data  = 16'hFFFF;
         in_shamt = 4'd0;
         in_arith = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("mid_pre_valid", 32'(out_valid), 1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(out_valid), 0);
      check("mid_rst_data", 32'(out_data), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      check("mid_no_stale", cnt, 0);
      @(posedge clk); #1;

      // Random traffic with random backpressure
      start = n_acc;
      cyc = 0;
      while (n_acc - start < 300 && cyc < 5000) begin
         in_valid  = ($urandom % 4) != 0;
         in_data   = 16'($urandom);
         in_shamt  = 4'($urandom);
         in_arith  = $urandom_range(0, 1) == 1;
         in_rot    = ROT_EN && ($urandom_range(0, 1) == 1);
         out_ready = ($urandom % 3) != 0;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("rand_accepted", n_acc - start, 300);
      check("rand_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
